// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU data-RAM access path: size codes,
// controller state encoding and the alignment predicate.
package cpu_mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    // ST_IDLE must stay encoded as zero so the reset state is all-zero.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_MERGE = 3'd2,
        ST_WRITE = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    // True for an illegal size or an access not aligned to its own size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return addr_lo[0];
            SZ_WORD: return (addr_lo != 2'b00);
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_ctrl_if.sv
// CPU request/response handshake plus the word-wide RAM port, bundled.
// slave = controller view, master = CPU datapath + RAM view.
interface ram_access_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              ram_ce;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, ram_ce, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, ram_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, ram_ce, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling between the RAM word and the CPU:
// load-side extract + sign/zero extend, store-side lane merge.
module mem_lane_align
    import cpu_mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] store_o
);
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic        sx;

    // Pick the addressed lane and extend it to a full word.
    always_comb begin
        byte_lane = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_lane = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        sx        = 1'b0;
        case (size_i)
            SZ_BYTE: begin
                sx     = ~unsigned_i & byte_lane[7];
                load_o = {{24{sx}}, byte_lane};
            end
            SZ_HALF: begin
                sx     = ~unsigned_i & half_lane[15];
                load_o = {{16{sx}}, half_lane};
            end
            default: load_o = rdata_i;
        endcase
    end

    // Overlay the right-aligned store data onto the addressed lane.
    always_comb begin
        store_o = rdata_i;
        case (size_i)
            SZ_BYTE: store_o[{addr_lo_i, 3'b000} +: 8] = wdata_i[7:0];
            SZ_HALF: begin
                if (addr_lo_i[1]) store_o[31:16] = wdata_i[15:0];
                else              store_o[15:0]  = wdata_i[15:0];
            end
            default: store_o = wdata_i;
        endcase
    end
endmodule

// File: rtl/ram_access_ctrl.sv
// CPU data-RAM controller: one request at a time, sub-word stores done
// as read-modify-write because the RAM only writes whole words.
module ram_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    ram_access_ctrl_if.slave  bus
);
    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;   // store data, later the merged write word
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;

    logic [31:0]       load_d;
    logic [31:0]       store_d;

    mem_lane_align u_align (
        .rdata_i    (bus.ram_rdata),
        .addr_lo_i  (addr_q[1:0]),
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_d),
        .store_o    (store_d)
    );

    // Request FSM: capture on accept, sequence RAM cycles, one-cycle response.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (bus.req_valid) begin
                    addr_q  <= bus.req_addr;
                    size_q  <= bus.req_size;
                    uns_q   <= bus.req_unsigned;
                    we_q    <= bus.req_we;
                    wdata_q <= bus.req_wdata;
                    rdata_q <= '0;
                    if (is_misaligned(bus.req_size, bus.req_addr[1:0])) begin
                        err_q   <= 1'b1;
                        state_q <= ST_RESP;
                    end else if (bus.req_we && bus.req_size == SZ_WORD) begin
                        state_q <= ST_WRITE;
                    end else begin
                        state_q <= ST_READ;
                    end
                end
                ST_READ:  state_q <= ST_MERGE;
                ST_MERGE: begin
                    if (we_q) begin
                        wdata_q <= store_d;
                        state_q <= ST_WRITE;
                    end else begin
                        rdata_q <= load_d;
                        state_q <= ST_RESP;
                    end
                end
                ST_WRITE: state_q <= ST_RESP;
                ST_RESP: begin
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default:  state_q <= ST_IDLE;
            endcase
        end
    end

    // RAM strobes are killed by reset so an aborted RMW never writes.
    assign bus.req_ready = (state_q == ST_IDLE) && !rst;
    assign bus.ram_ce    = ((state_q == ST_READ) || (state_q == ST_WRITE)) && !rst;
    assign bus.ram_we    = (state_q == ST_WRITE) && !rst;
    assign bus.ram_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.ram_wdata = (state_q == ST_WRITE) ? wdata_q : '0;
    assign bus.rsp_valid = (state_q == ST_RESP);
    assign bus.rsp_rdata = (state_q == ST_RESP) ? rdata_q : '0;
    assign bus.rsp_err   = (state_q == ST_RESP) && err_q;
endmodule

// File: tb/tb_ram_access_ctrl.sv
// Bench for ram_access_ctrl: behavioural word RAM, a byte-arithmetic
// reference memory, directed cases plus randomized traffic.
module tb_ram_access_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ram_access_ctrl_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    ram_access_ctrl #(.ADDR_W(16), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Word RAM with registered read; output is 0 unless a read was issued.
    logic [31:0] ram_arr [0:16383];
    logic [31:0] ram_q;
    always @(posedge clk) begin
        if (bus.ram_ce && bus.ram_we) ram_arr[bus.ram_addr[15:2]] <= bus.ram_wdata;
        ram_q <= (bus.ram_ce && !bus.ram_we) ? ram_arr[bus.ram_addr[15:2]] : 32'h0;
    end
    assign bus.ram_rdata = ram_q;

    // Reference memory and model results.
    logic [31:0] ref_mem [0:16383];
    logic [31:0] m_rd;
    logic        m_er;
    int          m_lat;

    // Observed results of the last transaction.
    logic [31:0] o_rd;
    logic        o_er;
    int          o_lat;
    logic        o_ce;
    logic        o_tail;

    task automatic model(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [15:0] a, input logic [31:0] wd);
        int idx, sh;
        logic [31:0] w, mask, v;
        idx = int'(a) / 4;
        sh  = (int'(a) % 4) * 8;
        m_rd = 32'h0;
        m_er = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd2 && (a % 4) != 0);
        if (m_er) begin
            m_lat = 1;
            return;
        end
        w = ref_mem[idx];
        if (!we) begin
            m_lat = 3;
            if (sz == 2'd2) m_rd = w;
            else if (sz == 2'd0) begin
                v = (w >> sh) & 32'hFF;
                if (!uns && v >= 128) v = v + 32'hFFFFFF00;
                m_rd = v;
            end else begin
                v = (w >> sh) & 32'hFFFF;
                if (!uns && v >= 32768) v = v + 32'hFFFF0000;
                m_rd = v;
            end
        end else if (sz == 2'd2) begin
            ref_mem[idx] = wd;
            m_lat = 2;
        end else begin
            mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
            ref_mem[idx] = (w & ~mask) | ((wd << sh) & mask);
            m_lat = 4;
        end
    endtask

    task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [15:0] a, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_we       = we;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = a;
        bus.req_wdata    = wd;
    endtask

    task automatic scramble();
        bus.req_valid    = 1'b0;
        bus.req_we       = 1'($urandom);
        bus.req_size     = 2'($urandom);
        bus.req_unsigned = 1'($urandom);
        bus.req_addr     = 16'($urandom);
        bus.req_wdata    = $urandom;
    endtask

    // One request through the DUT; inputs are scrambled right after accept.
    task automatic run_req(input logic we, input logic [1:0] sz, input logic uns,
                           input logic [15:0] a, input logic [31:0] wd);
        int n;
        @(negedge clk);
        drive(we, sz, uns, a, wd);
        n = 0;
        while (!bus.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        scramble();
        o_lat = 0; o_ce = 1'b0; o_rd = 32'h0; o_er = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
            if (bus.ram_ce) o_ce = 1'b1;
            if (bus.rsp_valid) begin
                o_lat = c;
                o_rd  = bus.rsp_rdata;
                o_er  = bus.rsp_err;
                break;
            end
        end
        @(negedge clk);
        o_tail = !bus.rsp_valid && (bus.rsp_rdata == 32'h0) && !bus.rsp_err;
    endtask

    task automatic test_reset();
        logic strobe_in_rst;
        strobe_in_rst = 1'b0;
        rst = 1'b1;
        drive(1'b1, 2'd2, 1'b0, 16'h0040, 32'hCAFEF00D);
        repeat (4) begin
            @(negedge clk);
            if (bus.ram_ce || bus.ram_we) strobe_in_rst = 1'b1;
        end
        scramble();
        rst = 1'b0;
        #1;
        tests++; if (strobe_in_rst !== 1'b0) begin fails++; $display("FAIL rst_strobe got %b exp 0", strobe_in_rst); end
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got %b exp 1", bus.req_ready); end
        tests++; if (bus.rsp_valid !== 1'b0) begin fails++; $display("FAIL rst_rsp_valid got %b exp 0", bus.rsp_valid); end
        tests++; if (bus.rsp_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata got %h exp 0", bus.rsp_rdata); end
        tests++; if (bus.rsp_err !== 1'b0) begin fails++; $display("FAIL rst_err got %b exp 0", bus.rsp_err); end
        tests++; if (bus.ram_ce !== 1'b0 || bus.ram_we !== 1'b0) begin fails++; $display("FAIL rst_ce_we got %b%b exp 00", bus.ram_ce, bus.ram_we); end
        tests++; if (bus.ram_wdata !== 32'h0 || bus.ram_addr !== 16'h0) begin fails++; $display("FAIL rst_ram_bus got %h/%h exp 0/0", bus.ram_wdata, bus.ram_addr); end
    endtask

    task automatic test_directed();
        model(1, 2'd2, 0, 16'h0000, 32'hDEADBEEF); run_req(1, 2'd2, 0, 16'h0000, 32'hDEADBEEF);
        tests++; if (o_lat != 2 || o_er !== 0 || o_rd !== 0 || !o_tail) begin fails++; $display("FAIL st_word got lat=%0d err=%b rd=%h tail=%b exp lat=2 err=0 rd=0 tail=1", o_lat, o_er, o_rd, o_tail); end
        model(0, 2'd2, 0, 16'h0000, 32'h0); run_req(0, 2'd2, 0, 16'h0000, 32'h0);
        tests++; if (o_lat != 3 || o_er !== 0 || o_rd !== 32'hDEADBEEF || !o_tail) begin fails++; $display("FAIL ld_word got lat=%0d err=%b rd=%h exp lat=3 err=0 rd=deadbeef", o_lat, o_er, o_rd); end

        model(1, 2'd2, 0, 16'h0000, 32'h12345678); run_req(1, 2'd2, 0, 16'h0000, 32'h12345678);
        model(1, 2'd0, 0, 16'h0001, 32'hFFFFFFAB); run_req(1, 2'd0, 0, 16'h0001, 32'hFFFFFFAB);
        tests++; if (o_lat != 4 || o_er !== 0 || ram_arr[0] !== 32'h1234AB78) begin fails++; $display("FAIL st_byte got lat=%0d ram=%h exp lat=4 ram=1234ab78", o_lat, ram_arr[0]); end
        model(0, 2'd0, 0, 16'h0001, 32'h0); run_req(0, 2'd0, 0, 16'h0001, 32'h0);
        tests++; if (o_rd !== 32'hFFFFFFAB || o_lat != 3) begin fails++; $display("FAIL ld_byte_s got %h lat=%0d exp ffffffab lat=3", o_rd, o_lat); end
        model(0, 2'd0, 1, 16'h0001, 32'h0); run_req(0, 2'd0, 1, 16'h0001, 32'h0);
        tests++; if (o_rd !== 32'h000000AB) begin fails++; $display("FAIL ld_byte_u got %h exp 000000ab", o_rd); end

        model(1, 2'd2, 0, 16'h0004, 32'h55555555); run_req(1, 2'd2, 0, 16'h0004, 32'h55555555);
        model(1, 2'd1, 0, 16'h0006, 32'h00008001); run_req(1, 2'd1, 0, 16'h0006, 32'h00008001);
        tests++; if (o_lat != 4 || ram_arr[1] !== 32'h80015555) begin fails++; $display("FAIL st_half got lat=%0d ram=%h exp lat=4 ram=80015555", o_lat, ram_arr[1]); end
        model(0, 2'd1, 0, 16'h0006, 32'h0); run_req(0, 2'd1, 0, 16'h0006, 32'h0);
        tests++; if (o_rd !== 32'hFFFF8001) begin fails++; $display("FAIL ld_half_s got %h exp ffff8001", o_rd); end
        model(0, 2'd1, 1, 16'h0006, 32'h0); run_req(0, 2'd1, 1, 16'h0006, 32'h0);
        tests++; if (o_rd !== 32'h00008001) begin fails++; $display("FAIL ld_half_u got %h exp 00008001", o_rd); end

        model(0, 2'd2, 0, 16'h0002, 32'h0); run_req(0, 2'd2, 0, 16'h0002, 32'h0);
        tests++; if (o_lat != 1 || o_er !== 1 || o_rd !== 0 || o_ce !== 0 || !o_tail) begin fails++; $display("FAIL err_ld_word got lat=%0d err=%b rd=%h ce=%b exp lat=1 err=1 rd=0 ce=0", o_lat, o_er, o_rd, o_ce); end
        model(1, 2'd1, 0, 16'h0003, 32'h1234); run_req(1, 2'd1, 0, 16'h0003, 32'h1234);
        tests++; if (o_lat != 1 || o_er !== 1 || o_rd !== 0 || o_ce !== 0) begin fails++; $display("FAIL err_st_half got lat=%0d err=%b rd=%h ce=%b exp lat=1 err=1 rd=0 ce=0", o_lat, o_er, o_rd, o_ce); end
        model(0, 2'd3, 0, 16'h0000, 32'h0); run_req(0, 2'd3, 0, 16'h0000, 32'h0);
        tests++; if (o_lat != 1 || o_er !== 1 || o_ce !== 0) begin fails++; $display("FAIL err_size3 got lat=%0d err=%b ce=%b exp lat=1 err=1 ce=0", o_lat, o_er, o_ce); end
    endtask

    task automatic test_random();
        logic        we, uns;
        logic [1:0]  sz;
        logic [15:0] a;
        logic [31:0] wd;
        int          bad;
        for (int i = 0; i < 16; i++) begin
            wd = $urandom;
            model(1, 2'd2, 0, 16'(i * 4), wd);
            run_req(1, 2'd2, 0, 16'(i * 4), wd);
        end
        for (int i = 0; i < 150; i++) begin
            we  = 1'($urandom);
            sz  = 2'($urandom);
            uns = 1'($urandom);
            a   = 16'($urandom_range(0, 63));
            wd  = $urandom;
            model(we, sz, uns, a, wd);
            run_req(we, sz, uns, a, wd);
            tests++;
            if (o_rd !== m_rd || o_er !== m_er || o_lat != m_lat || o_ce !== !m_er || !o_tail) begin
                fails++;
                $display("FAIL rand[%0d] we=%b sz=%0d u=%b a=%h wd=%h got rd=%h err=%b lat=%0d ce=%b tail=%b exp rd=%h err=%b lat=%0d", i, we, sz, uns, a, wd, o_rd, o_er, o_lat, o_ce, o_tail, m_rd, m_er, m_lat);
            end
        end
        bad = 0;
        for (int i = 0; i < 16; i++) if (ram_arr[i] !== ref_mem[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL rand_ram_image got %0d differing words exp 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic we_seen, rsp_seen;
        int   n;
        model(1, 2'd2, 0, 16'h0008, 32'hAAAAAAAA); run_req(1, 2'd2, 0, 16'h0008, 32'hAAAAAAAA);
        we_seen = 1'b0; rsp_seen = 1'b0;
        @(negedge clk);
        drive(1, 2'd0, 0, 16'h0008, 32'h000000FF);
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        scramble();
        @(negedge clk);                 // READ
        if (bus.ram_we) we_seen = 1'b1;
        @(negedge clk);                 // MERGE
        rst = 1'b1;
        if (bus.ram_we) we_seen = 1'b1;
        @(negedge clk);
        if (bus.ram_we || bus.ram_ce) we_seen = 1'b1;
        rst = 1'b0;
        #1;
        tests++; if (bus.req_ready !== 1'b1) begin fails++; $display("FAIL rmid_ready got %b exp 1", bus.req_ready); end
        repeat (4) begin
            @(negedge clk);
            if (bus.ram_we) we_seen = 1'b1;
            if (bus.rsp_valid) rsp_seen = 1'b1;
        end
        tests++; if (we_seen !== 1'b0) begin fails++; $display("FAIL rmid_we got %b exp 0", we_seen); end
        tests++; if (rsp_seen !== 1'b0) begin fails++; $display("FAIL rmid_rsp got %b exp 0", rsp_seen); end
        model(0, 2'd2, 0, 16'h0008, 32'h0); run_req(0, 2'd2, 0, 16'h0008, 32'h0);
        tests++; if (o_rd !== 32'hAAAAAAAA || o_lat != 3) begin fails++; $display("FAIL rmid_readback got %h lat=%0d exp aaaaaaaa lat=3", o_rd, o_lat); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v0, v1;
        logic [6:0]  rspv, rdy;
        int          n;
        v0 = $urandom; v1 = $urandom;
        model(1, 2'd2, 0, 16'h000C, v0);
        model(1, 2'd2, 0, 16'h0010, v1);
        rspv = '0; rdy = '0;
        @(negedge clk);
        drive(1, 2'd2, 0, 16'h000C, v0);
        n = 0;
        while (!bus.req_ready && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        bus.req_addr  = 16'h0010;       // valid stays high
        bus.req_wdata = v1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            rspv[k] = bus.rsp_valid;
            rdy[k]  = bus.req_ready;
        end
        @(posedge clk);
        #1;
        scramble();
        for (int k = 4; k <= 6; k++) begin
            @(negedge clk);
            rspv[k] = bus.rsp_valid;
            rdy[k]  = bus.req_ready;
        end
        tests++; if (rspv !== 7'b0100100) begin fails++; $display("FAIL b2b_rsp_cycles got %b exp 0100100", rspv); end
        tests++; if (rdy[3:1] !== 3'b100) begin fails++; $display("FAIL b2b_ready got %b exp 100", rdy[3:1]); end
        model(0, 2'd2, 0, 16'h000C, 32'h0); run_req(0, 2'd2, 0, 16'h000C, 32'h0);
        tests++; if (o_rd !== v0) begin fails++; $display("FAIL b2b_read0 got %h exp %h", o_rd, v0); end
        model(0, 2'd2, 0, 16'h0010, 32'h0); run_req(0, 2'd2, 0, 16'h0010, 32'h0);
        tests++; if (o_rd !== v1) begin fails++; $display("FAIL b2b_read1 got %h exp %h", o_rd, v1); end
    endtask

    initial begin
        scramble();
        test_reset();
        test_directed();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Initiator-side controller for the CPU's data RAM port. It accepts load/store requests from the CPU datapath over a valid/ready handshake and issues the matching word-wide `ce`/`we`/`addr`/`data_in` cycles to `ram_module`. It returns load data with byte/halfword extraction and sign/zero extension. Byte and halfword stores are done as read-modify-write, because the RAM only writes whole 32-bit words.

## Interface
Parameters:
- `ADDR_W`, 16, byte address width (RAM `addr` width)
- `DATA_W`, 32, data word width; fixed at 32

Ports:
- `clk` in 1: single clock; all state changes on the rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: controller can accept; high only in IDLE
- `req_we` in 1: 1 = store, 0 = load
- `req_size` in 2: 00 = byte, 01 = half, 10 = word, 11 = illegal
- `req_unsigned` in 1: load zero-extends when 1, sign-extends when 0
- `req_addr` in ADDR_W: byte address
- `req_wdata` in 32: store data, right-aligned (bits [7:0] for a byte, [15:0] for a half)
- `rsp_valid` out 1: one-cycle completion pulse; no backpressure
- `rsp_rdata` out 32: formatted load data; 0 for stores and errors
- `rsp_err` out 1: misaligned or illegal-size request; valid with `rsp_valid`
- `ram_ce`, `ram_we` out 1: to RAM `ce`, `we`
- `ram_addr` out ADDR_W: to RAM `addr`, always word-aligned as {`req_addr[ADDR_W-1:2]`, 2'b00}
- `ram_wdata` out 32: to RAM `data_in`
- `ram_rdata` in 32: from RAM `data_out`

## Operation
- **RAM contract**
  - Write occurs at the rising edge when `ce` and `we` are both high.
  - Read data is valid on `data_out` in the cycle after `ce`=1, `we`=0 with the address presented.
  - `data_out` is 0 while `ce` is 0.
- **Lanes:** little-endian.
  - Byte k = bits [8k+7:8k], with k = `addr[1:0]`.
  - Half = bits [15:0] when `addr[1]`=0, bits [31:16] when `addr[1]`=1.
- **Request capture:** fields are latched on the accept edge (`req_valid` && `req_ready`). Inputs are ignored afterwards.
- **FSM states:** IDLE, READ, MERGE, WRITE, RESP.
  - IDLE, illegal or misaligned request → RESP with err. Misaligned means a half with `addr[0]`=1, a word with `addr[1:0]`≠0, or size 11.
  - IDLE, word store → WRITE.
  - IDLE, any load or sub-word store → READ.
  - READ: drive `ram_ce`=1, `ram_we`=0, `ram_addr`. Next state MERGE.
  - MERGE: sample `ram_rdata`.
    - Load: register the formatted word into `rsp_rdata`, then → RESP.
    - Sub-word store: replace the target lane with `req_wdata` low bits, keep the other lanes, register as the write word, then → WRITE.
  - WRITE: drive `ram_ce`=1, `ram_we`=1, `ram_addr`, `ram_wdata`. Next state RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, then → IDLE.
- **Extension:** byte and half loads extend from bit 7 or bit 15 of the extracted lane. `req_unsigned` has no effect on word loads or on stores.
- **RAM access outside READ/WRITE:** `ram_ce`=`ram_we`=0 and `ram_wdata`=0.

## Timing
- **Latency**, counted in cycles from the accept edge to the `rsp_valid` cycle:
  - Error: 1, with no RAM access (`ram_ce` never asserted).
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- **Throughput:** at most one request outstanding. With `req_valid` held high, the next accept is in the cycle after RESP.
- **Reset values:** state IDLE; `req_ready`=1 once `rst` deasserts; all other outputs and internal registers are 0.
- **Reset mid-operation:**
  - `ram_ce` and `ram_we` are gated by `!rst`, so no RAM access happens in any cycle where `rst` is high.
  - The in-flight request is dropped with no response.
  - A sub-word store reset in READ or MERGE leaves the RAM word unchanged.
- **Outputs:** `rsp_rdata` and `rsp_err` hold their value only during `rsp_valid`; they are 0 otherwise.

## Structure
- **Shared package `cpu_mem_pkg`:** size encodings (SZ_BYTE, SZ_HALF, SZ_WORD), the FSM state enum, and the misalignment predicate function.
- **Sub-module `mem_lane_align`:** purely combinational.
  - Load path: lane extract plus sign/zero extension.
  - Store path: lane merge.
  - The controller instantiates it once, between `ram_rdata` and the MERGE registers.

## Test plan
- Word store 0xDEADBEEF @0x0000, then word load @0x0000 → `rsp_valid` 2 and 3 cycles after accept respectively; `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- Word store 0x12345678 @0x0000, then byte store 0xAB @0x0001 → RAM word 0x1234AB78. Signed byte load @0x0001 → 0xFFFFFFAB. Unsigned byte load → 0x000000AB.
- Word store 0x55555555 @0x0004, then half store 0x8001 @0x0006 → RAM word 0x80015555. Signed half load @0x0006 → 0xFFFF8001. Unsigned half load → 0x00008001.
- Word load @0x0002 and half store @0x0003 → `rsp_err`=1 with `rsp_valid` 1 cycle after accept, `rsp_rdata`=0, and `ram_ce` low throughout.
- Byte store 0xFF @0x0008 over 0xAAAAAAAA, with `rst` pulsed during MERGE → `ram_we` never asserts, `req_ready`=1 after reset, and a subsequent word load @0x0008 returns 0xAAAAAAAA.
- `req_valid` held high for two word stores (@0x000C then @0x0010) → second accepted in the cycle after the first RESP, and both values read back correctly.
